// File: rtl/selftrig_pkg.sv
// Shared types and constants for the self-trigger frame capture block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package selftrig_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int TS_W      = 64;
    localparam int HDR_WORDS = 5;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        IDLE    = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    // Header word order: timestamp from the most significant half-word down, then baseline.
    function automatic logic [SAMPLE_W-1:0] hdr_word(
        input logic [TS_W-1:0]     ts,
        input logic [SAMPLE_W-1:0] bl,
        input logic [2:0]          idx
    );
        case (idx)
            3'd0:    hdr_word = ts[63:48];
            3'd1:    hdr_word = ts[47:32];
            3'd2:    hdr_word = ts[31:16];
            3'd3:    hdr_word = ts[15:0];
            default: hdr_word = bl;
        endcase
    endfunction

endpackage

// File: rtl/selftrig_ring_ram.sv
// Simple dual-port ring RAM: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; rd_data holds while rd_en is low.
module selftrig_ring_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/selftrigger_frame_capture.sv
// Turns each accepted trigger into one pre/post-trigger frame; SELFTRIG_CAPTURE_HDR_EN prepends a 5-word header.
// Latency: first word two cycles after entering READOUT, then one word per cycle under continuous ready.
// Backpressure: dout_ready stalls only the readout stream; din is never stalled, stalls extend dead time.
module selftrigger_frame_capture
    import selftrig_pkg::*;
#(
    parameter int ADDR_W       = 9,
    parameter int PRE_SAMPLES  = 64,
    parameter int POST_SAMPLES = 192
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [TS_W-1:0]     timestamp,
    input  logic [SAMPLE_W-1:0] din,
    input  logic [SAMPLE_W-1:0] baseline,
    input  logic                trigger,
    output logic [SAMPLE_W-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                busy,
    output logic [15:0]         missed_count
);

    localparam int CNT_W = ADDR_W + 2;
`ifdef SELFTRIG_CAPTURE_HDR_EN
    localparam int HDR_N = HDR_WORDS;
`else
    localparam int HDR_N = 0;
`endif
    localparam logic [CNT_W-1:0]  TOTAL    = CNT_W'(HDR_N + PRE_SAMPLES + POST_SAMPLES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(HDR_N + PRE_SAMPLES + POST_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  PRE_M1   = CNT_W'(PRE_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  POST_M1  = CNT_W'(POST_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_SAMPLES);

    state_t state, state_nxt;

    logic                trigger_d1;
    logic                trig_edge;
    logic                accept;
    logic                frame_done;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]    fill_cnt;
    logic [CNT_W-1:0]    post_cnt;
    logic [CNT_W-1:0]    iss_cnt;

    logic                issue;
    logic                issue_hdr;
    logic                infl;
    logic                infl_last;
    logic                pf_vld;
    logic                pf_last;
    logic [SAMPLE_W-1:0] pf_dat;
    logic [SAMPLE_W-1:0] ram_q;
    logic [SAMPLE_W-1:0] src_dat;
    logic [1:0]          occ_after;
    logic                dout_free;

    assign trig_edge  = trigger & ~trigger_d1;
    assign accept     = (state == IDLE) && trig_edge && enable;
    assign frame_done = (state == READOUT) && dout_valid && dout_ready && dout_last;
    assign wr_en      = (state != READOUT);
    assign busy       = (state == CAPTURE) || (state == READOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // The capture counter reaches zero in the cycle the last post-trigger sample is written.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (fill_cnt == PRE_M1) state_nxt = IDLE;
            IDLE:    if (accept) state_nxt = (POST_SAMPLES == 1) ? READOUT : CAPTURE;
            CAPTURE: if (post_cnt == ONE) state_nxt = READOUT;
            READOUT: if (frame_done) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    selftrig_ring_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ring (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (issue && !issue_hdr),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Words held in dout, the prefetch slot or in flight from the RAM never exceed two.
    assign occ_after = {1'b0, dout_valid & ~dout_ready} + {1'b0, pf_vld} + {1'b0, infl};
    assign issue     = (state == READOUT) && (iss_cnt != TOTAL) && (occ_after < 2'd2);
    assign dout_free = ~dout_valid | dout_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            trigger_d1   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            iss_cnt      <= '0;
            missed_count <= '0;
        end else begin
            trigger_d1 <= trigger;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (state == FILL) begin
                fill_cnt <= fill_cnt + ONE;
            end else if (frame_done) begin
                fill_cnt <= '0;
            end
            if (accept) begin
                rd_ptr   <= wr_ptr - PRE_OFS;
                post_cnt <= POST_M1;
                iss_cnt  <= '0;
            end else if (state == CAPTURE) begin
                post_cnt <= post_cnt - ONE;
            end
            if (issue) begin
                iss_cnt <= iss_cnt + ONE;
                if (!issue_hdr) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end
            if (busy && trig_edge && enable && (missed_count != 16'hFFFF)) begin
                missed_count <= missed_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            infl       <= 1'b0;
            infl_last  <= 1'b0;
            pf_vld     <= 1'b0;
            pf_last    <= 1'b0;
            pf_dat     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            infl      <= issue;
            infl_last <= (iss_cnt == LAST_IDX);
            if (dout_free) begin
                if (pf_vld) begin
                    dout       <= pf_dat;
                    dout_last  <= pf_last;
                    dout_valid <= 1'b1;
                    pf_vld     <= infl;
                    pf_dat     <= src_dat;
                    pf_last    <= infl_last;
                end else if (infl) begin
                    dout       <= src_dat;
                    dout_last  <= infl_last;
                    dout_valid <= 1'b1;
                end else begin
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                end
            end else if (infl) begin
                pf_vld  <= 1'b1;
                pf_dat  <= src_dat;
                pf_last <= infl_last;
            end
        end
    end

`ifdef SELFTRIG_CAPTURE_HDR_EN
    logic [TS_W-1:0]     ts_q;
    logic [SAMPLE_W-1:0] bl_q;
    logic                infl_hdr;
    logic [SAMPLE_W-1:0] hdr_dat;

    // Header words ride the same one-cycle pipe as RAM reads so the output path is shared.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            bl_q     <= '0;
            infl_hdr <= 1'b0;
            hdr_dat  <= '0;
        end else begin
            if (accept) begin
                ts_q <= timestamp;
                bl_q <= baseline;
            end
            infl_hdr <= issue && issue_hdr;
            hdr_dat  <= hdr_word(ts_q, bl_q, iss_cnt[2:0]);
        end
    end

    assign issue_hdr = (iss_cnt < CNT_W'(HDR_WORDS));
    assign src_dat   = infl_hdr ? hdr_dat : ram_q;
`else
    logic unused_hdr_inputs;

    assign unused_hdr_inputs = ^{timestamp, baseline};
    assign issue_hdr         = 1'b0;
    assign src_dat           = ram_q;
`endif

endmodule

// File: tb/tb_selftrigger_frame_capture.sv
// Scoreboard bench for selftrigger_frame_capture with PRE=4, POST=8, ADDR_W=4 and a ramp on din.
// Expected frames are pushed when a trigger is driven and popped as words are handshaken.
module tb_selftrigger_frame_capture;

    localparam int ADDR_W = 4;
    localparam int PRE    = 4;
    localparam int POST   = 8;
    localparam int NW     = PRE + POST;
`ifdef SELFTRIG_CAPTURE_HDR_EN
    localparam int HW = 5;
`else
    localparam int HW = 0;
`endif

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        enable     = 1'b1;
    logic        trigger    = 1'b0;
    logic        dout_ready = 1'b1;
    logic [63:0] timestamp  = 64'h0123_4567_89AB_CDEF;
    logic [15:0] din        = 16'd0;
    logic [15:0] baseline   = 16'hFFFB;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        busy;
    logic [15:0] missed_count;

    int tests      = 0;
    int errs       = 0;
    int words_seen = 0;
    logic [16:0] exp_q [$];

    selftrigger_frame_capture #(
        .ADDR_W       (ADDR_W),
        .PRE_SAMPLES  (PRE),
        .POST_SAMPLES (POST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .timestamp    (timestamp),
        .din          (din),
        .baseline     (baseline),
        .trigger      (trigger),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .busy         (busy),
        .missed_count (missed_count)
    );

    always #5 clk = ~clk;

    // din is a ramp advancing once per cycle
    initial begin
        forever begin
            @(negedge clk);
            din = din + 16'd1;
        end
    end

    // Output monitor: sampled after the drivers settle, ahead of the next rising edge.
    initial begin
        logic        held;
        logic [16:0] held_w;
        logic [16:0] e;
        held = 1'b0;
        held_w = '0;
        forever begin
            @(negedge clk);
            #3;
            if (held) begin
                tests++;
                if (!dout_valid || ({dout_last, dout} !== held_w)) begin
                    errs++;
                    $display("FAIL hold_stable: got vld=%b last=%b dout=%h, want vld=1 last=%b dout=%h",
                             dout_valid, dout_last, dout, held_w[16], held_w[15:0]);
                end
            end
            held = 1'b0;
            if (dout_valid && dout_ready) begin
                words_seen++;
                tests++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_word: got dout=%h last=%b, want no word", dout, dout_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout_last, dout} !== e) begin
                        errs++;
                        $display("FAIL frame_word: got dout=%h last=%b, want dout=%h last=%b",
                                 dout, dout_last, e[15:0], e[16]);
                    end
                end
            end else if (dout_valid) begin
                held   = 1'b1;
                held_w = {dout_last, dout};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d words pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        trigger    = 1'b0;
        dout_ready = 1'b1;
        step(2);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Trigger is seen high at the rising edge after the first step; tv is din at that edge.
    task automatic pulse(output logic [15:0] tv);
        step(1);
        trigger = 1'b1;
        tv      = din;
        step(1);
        trigger = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] tv);
        logic [15:0] v;
        if (HW != 0) begin
            exp_q.push_back({1'b0, timestamp[63:48]});
            exp_q.push_back({1'b0, timestamp[47:32]});
            exp_q.push_back({1'b0, timestamp[31:16]});
            exp_q.push_back({1'b0, timestamp[15:0]});
            exp_q.push_back({1'b0, baseline});
        end
        for (int k = 0; k < NW; k++) begin
            v = tv - 16'(PRE) + 16'(k);
            exp_q.push_back({(k == NW - 1), v});
        end
    endtask

    task automatic wait_done(input string name, input bit toggle, output int span);
        int n;
        int first;
        int last;
        n     = 0;
        first = -1;
        last  = -1;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            if (dout_valid) begin
                if (first < 0) first = n;
                last = n;
            end
            step(1);
            if (toggle) dout_ready = ~dout_ready;
            n++;
        end
        dout_ready = 1'b1;
        span = (first < 0) ? 0 : last - first + 1;
        tests++;
        if (exp_q.size() != 0 || busy) begin
            errs++;
            $display("FAIL %s_timeout: got %0d words pending busy=%b, want 0 pending busy=0", name, exp_q.size(), busy);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!dout_valid && n < 60) begin
            step(1);
            n++;
        end
        tests++;
        if (!dout_valid) begin
            errs++;
            $display("FAIL %s_no_readout: got dout_valid=0, want 1 within 60 cycles", name);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dout_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        tests++;
        if (dout_last !== 1'b0) begin errs++; $display("FAIL reset_last: got %b want 0", dout_last); end
        tests++;
        if (dout !== 16'h0) begin errs++; $display("FAIL reset_dout: got %h want 0000", dout); end
        tests++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++;
        if (missed_count !== 16'h0) begin errs++; $display("FAIL reset_missed: got %0d want 0", missed_count); end
    endtask

    task automatic test_single();
        logic [15:0] tv;
        int          span;
        int          n;
        n = 0;
        while (din != 16'd99 && n < 200) begin
            step(1);
            n++;
        end
        pulse(tv);
        tests++;
        if (tv !== 16'd100) begin errs++; $display("FAIL single_trig_sample: got %0d want 100", tv); end
        push_frame(tv);
        wait_done("single", 1'b0, span);
        tests++;
        if (span != NW + HW) begin errs++; $display("FAIL single_gapfree: got span %0d want %0d", span, NW + HW); end
        tests++;
        if (busy !== 1'b0) begin errs++; $display("FAIL single_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_fill_ignore(input string name);
        logic [15:0] tv;
        int          seen;
        int          span;
        seen = words_seen;
        pulse(tv);
        step(2);
        tests++;
        if (busy !== 1'b0) begin errs++; $display("FAIL %s_fill_busy: got %b want 0", name, busy); end
        step(20);
        tests++;
        if (words_seen != seen) begin errs++; $display("FAIL %s_fill_frame: got %0d words want 0", name, words_seen - seen); end
        tests++;
        if (missed_count !== 16'h0) begin errs++; $display("FAIL %s_fill_missed: got %0d want 0", name, missed_count); end
        pulse(tv);
        push_frame(tv);
        wait_done(name, 1'b0, span);
    endtask

    task automatic test_missed();
        logic [15:0] tv;
        logic [15:0] t2;
        int          span;
        do_reset();
        step(6);
        pulse(tv);
        push_frame(tv);
        step(2);
        pulse(t2);
        wait_valid("missed");
        pulse(t2);
        wait_done("missed", 1'b0, span);
        tests++;
        if (missed_count !== 16'd2) begin errs++; $display("FAIL missed_count: got %0d want 2", missed_count); end
    endtask

    task automatic test_backpressure();
        logic [15:0] tv;
        int          span;
        do_reset();
        step(8);
        pulse(tv);
        push_frame(tv);
        wait_done("backpressure", 1'b1, span);
    endtask

    task automatic test_wrap();
        logic [15:0] tv;
        int          span;
        do_reset();
        step(16);
        pulse(tv);
        push_frame(tv);
        wait_done("wrap", 1'b0, span);
    endtask

    task automatic test_header();
        logic [15:0] tv;
        int          span;
        do_reset();
        baseline = 16'hFFFB;
        step(8);
        pulse(tv);
        push_frame(tv);
        wait_done("header", 1'b0, span);
    endtask

    task automatic test_reset_mid();
        logic [15:0] tv;
        do_reset();
        step(6);
        pulse(tv);
        push_frame(tv);
        wait_valid("reset_mid");
        step(3);
        reset = 1'b1;
        step(1);
        tests++;
        if (dout_valid !== 1'b0) begin errs++; $display("FAIL reset_mid_valid: got %b want 0", dout_valid); end
        tests++;
        if (dout_last !== 1'b0) begin errs++; $display("FAIL reset_mid_last: got %b want 0", dout_last); end
        tests++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        exp_q.delete();
        step(1);
        reset = 1'b0;
        test_fill_ignore("after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_ignore("fill");
        test_missed();
        test_backpressure();
        test_wrap();
        test_header();
        test_reset_mid();
        step(5);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/selftrigger_frame_capture.md
Name: selftrigger_frame_capture

Overview:
- Consumer end of the self-trigger filter output: takes the filtered sample stream, the baseline and the trigger pulse, and turns each accepted trigger into one framed waveform record.
- Keeps a pre-trigger ring buffer, captures post-trigger samples, then streams an optional header plus samples over a valid/ready stream toward the channel readout.
- Sits directly after the per-channel filter/trigger block, one instance per channel.

Parameters:
- ADDR_W, 9, ring buffer address width (depth 2^ADDR_W samples).
- PRE_SAMPLES, 64, samples before the trigger sample included in the frame.
- POST_SAMPLES, 192, trigger sample plus following samples. Constraint: PRE_SAMPLES+POST_SAMPLES <= 2^ADDR_W, PRE_SAMPLES >= 1, POST_SAMPLES >= 1.

Ports:
- clk  in  1  sample clock; one sample per cycle
- reset  in  1  synchronous, active-high
- enable  in  1  trigger acceptance enable; does not gate ring writes
- timestamp  in  64  free-running sample timestamp
- din  in  16  signed filtered sample
- baseline  in  16  signed current baseline estimate
- trigger  in  1  trigger level/pulse from discriminator
- dout  out  16  stream data
- dout_valid  out  1  stream valid
- dout_ready  in  1  stream ready
- dout_last  out  1  marks final word of frame
- busy  out  1  high in CAPTURE or READOUT
- missed_count  out  16  saturating count of rejected triggers

Behaviour:
- Reset (synchronous, active-high): state FILL; wr_ptr=0, fill count=0, missed_count=0; dout=0, dout_valid=0, dout_last=0, busy=0. Reset mid-frame drops dout_valid next cycle with no dout_last; the partial frame is discarded.
- Trigger edge: trig_edge = trigger & ~trigger_d1 (trigger_d1 registered, reset to 0).
- Ring write: din written at wr_ptr, wr_ptr wraps mod 2^ADDR_W, every cycle in FILL, IDLE and CAPTURE. No writes in READOUT; wr_ptr holds.
- FILL:
  - Counts writes and moves to IDLE after PRE_SAMPLES writes.
  - Trigger edges are ignored and not counted.
- IDLE:
  - On trig_edge & enable: latch trig_addr=wr_ptr (the sample at this cycle is the trigger sample), timestamp and baseline.
  - Load post counter = POST_SAMPLES-1 and go to CAPTURE, or straight to READOUT if POST_SAMPLES=1.
- CAPTURE:
  - Writes continue; the counter decrements each cycle.
  - At 0 (last post sample written this cycle), go to READOUT next cycle.
- READOUT:
  - rd_ptr starts at (trig_addr - PRE_SAMPLES) mod depth.
  - Emits PRE_SAMPLES+POST_SAMPLES samples, oldest first.
  - The ring is a 1-cycle-latency synchronous RAM. A prefetch register keeps the stream gap-free under continuous dout_ready.
  - dout/dout_last are held stable while dout_valid & ~dout_ready.
  - After the handshake of the dout_last word, go to FILL with fill count=0, so fresh pre-trigger data is required.
- Missed triggers: trig_edge & enable in CAPTURE or READOUT increments missed_count, saturating at 16'hFFFF. A trig_edge in the same cycle as the FILL->IDLE transition is ignored.
- busy = state is CAPTURE or READOUT.
- Frame length is fixed. No backpressure on din: a stall in READOUT only extends dead time.

Optional Feature:
- Macro SELFTRIG_CAPTURE_HDR_EN.
- Defined: each frame starts with 5 header words, then the samples:
  - timestamp[63:48], [47:32], [31:16], [15:0];
  - latched baseline.
  - dout_last applies only to the final sample.
  - The header is sourced from latched registers and needs no RAM read.
- Undefined: the frame is samples only; the timestamp/baseline latches are removed.

Decomposition:
- Shared package selftrig_pkg:
  - state enum (FILL, IDLE, CAPTURE, READOUT);
  - SAMPLE_W=16, TS_W=64, HDR_WORDS=5.
- Sub-module selftrig_ring_ram: simple dual-port RAM, 2^ADDR_W x 16, one write port, one registered read port.

Test Plan (PRE_SAMPLES=4, POST_SAMPLES=8, ADDR_W=4, din = ramp equal to cycle count, continuous dout_ready, header off unless stated):
- Single trigger: trigger 0->1 while din=100 -> frame 96..107 (12 words, back-to-back), dout_last on 107, then state FILL and busy=0.
- Trigger during FILL (2 cycles after reset) -> no frame, missed_count=0; the next trigger after 4 writes is accepted.
- Second trigger edge during CAPTURE and one during READOUT -> missed_count=2, the first frame is unchanged.
- Backpressure: dout_ready toggles 1/0 every cycle -> same 12 values in order, dout stable while not ready, no duplicates or drops.
- Ring wrap: trigger at wr_ptr=1 -> rd_ptr starts at 13, samples are still consecutive ramp values.
- Header on (SELFTRIG_CAPTURE_HDR_EN), timestamp=64'h0123_4567_89AB_CDEF, baseline=-5 -> words 0123, 4567, 89AB, CDEF, FFFB, then 12 samples.
- Reset asserted mid-READOUT -> dout_valid=0 next cycle; the next frame needs 4 fresh samples.
